// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared constants and helpers for the handshake token blocks
//
// HS_CONST_64 : default reference constant compared against incoming tokens
// ptr_width() : pointer width for a buffer of 'depth' slots (clog2, minimum 1)
package handshake_pkg;

   localparam logic [16:0] HS_CONST_64 = 17'b01000000011100111;

   function automatic int ptr_width(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/handshake_flag_fifo.sv
// rtl/handshake_flag_fifo.sv - 1-bit-wide synchronous FIFO with explicit occupancy counter
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears pointers and occupancy)
//   push     : write din at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   din      : flag written on push
//   dout     : flag at the head (meaningful only when !empty)
//   empty    : occupancy == 0
//   full     : occupancy == DEPTH
module handshake_flag_fifo
   import handshake_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic empty,
   output logic full
);

   localparam int                PTR_W    = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   // One extra bit so the counter can hold DEPTH itself.
   localparam logic [PTR_W:0]    FULL_OCC = (PTR_W + 1)'(DEPTH);

   logic [DEPTH-1:0] slots;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   occ;
   logic             do_push;
   logic             do_pop;

   assign empty   = (occ == '0);
   assign full    = (occ == FULL_OCC);
   assign dout    = slots[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap explicitly at DEPTH so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         unique case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Slot contents need no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         slots[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/handshake_token_match.sv
// rtl/handshake_token_match.sv - compare data tokens to a constant, route as match/miss control tokens
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ins, ins_valid, ins_ready: input data token channel
//   match_valid, match_ready : control token for heads equal to CONST_VALUE
//   miss_valid,  miss_ready  : control token for heads different from CONST_VALUE
//   match_count, miss_count  : saturating counts of completed match / miss transfers
module handshake_token_match
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter     CONST_VALUE = HS_CONST_64,
   parameter int DEPTH       = 2,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  ins,
   input  logic                   ins_valid,
   output logic                   ins_ready,
   output logic                   match_valid,
   input  logic                   match_ready,
   output logic                   miss_valid,
   input  logic                   miss_ready,
   output logic [COUNT_WIDTH-1:0] match_count,
   output logic [COUNT_WIDTH-1:0] miss_count
);

   // Zero-extends or truncates the constant to the data width.
   localparam logic [DATA_WIDTH-1:0] REF_VALUE = DATA_WIDTH'(CONST_VALUE);

   logic fifo_empty;
   logic fifo_full;
   logic head_flag;
   logic push;
   logic match_pop;
   logic miss_pop;

   // Only registered occupancy feeds ins_ready; a pop in the same cycle
   // does not free the slot early.
   assign ins_ready   = !rst && !fifo_full;
   assign push        = ins_valid && ins_ready;

   assign match_valid = !rst && !fifo_empty && head_flag;
   assign miss_valid  = !rst && !fifo_empty && !head_flag;
   assign match_pop   = match_valid && match_ready;
   assign miss_pop    = miss_valid && miss_ready;

   handshake_flag_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (match_pop || miss_pop),
      .din   (ins == REF_VALUE),
      .dout  (head_flag),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         match_count <= '0;
         miss_count  <= '0;
      end else begin
         if (match_pop && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
         end
         if (miss_pop && (miss_count != '1)) begin
            miss_count <= miss_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_handshake_token_match.sv
// tb/tb_handshake_token_match.sv - self-checking bench for handshake_token_match
module tb_handshake_token_match;

   localparam int          DW      = 32;
   localparam int          DEPTH   = 2;
   localparam int          CW      = 4;
   localparam int          CNT_MAX = 15;
   localparam logic [31:0] TOK_M   = 32'h0000_80E7;
   localparam logic [31:0] TOK_X   = 32'h0000_80E6;

   logic          clk;
   logic          rst;
   logic [DW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic          match_valid;
   logic          match_ready;
   logic          miss_valid;
   logic          miss_ready;
   logic [CW-1:0] match_count;
   logic [CW-1:0] miss_count;

   handshake_token_match #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ins         (ins),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .match_valid (match_valid),
      .match_ready (match_ready),
      .miss_valid  (miss_valid),
      .miss_ready  (miss_ready),
      .match_count (match_count),
      .miss_count  (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: queue of match flags plus two saturating counts.
   bit q[$];
   int m_mc = 0;
   int m_sc = 0;

   typedef struct {
      bit          r;
      logic [31:0] d;
      bit          v;
      bit          m;
      bit          s;
      bit          e_ir;
      bit          e_mv;
      bit          e_sv;
      int          e_mc;
      int          e_sc;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input logic [31:0] d, input bit v, input bit m, input bit s);
      rst         = r;
      ins         = d;
      ins_valid   = v;
      match_ready = m;
      miss_ready  = s;
   endtask

   function automatic void model_step(input bit r, input logic [31:0] d, input bit v,
                                      input bit m, input bit s);
      bit can_push;
      bit head_ok;
      if (r) begin
         q.delete();
         m_mc = 0;
         m_sc = 0;
         return;
      end
      can_push = v && (q.size() < DEPTH);
      if (q.size() > 0) begin
         head_ok = q[0] ? m : s;
         if (head_ok) begin
            if (q[0]) m_mc = (m_mc < CNT_MAX) ? m_mc + 1 : CNT_MAX;
            else      m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
            void'(q.pop_front());
         end
      end
      if (can_push) q.push_back(d == TOK_M);
   endfunction

   // One clock with model-derived expectations for every output.
   task automatic do_cycle(input string tag, input bit r, input logic [31:0] d,
                           input bit v, input bit m, input bit s);
      bit e_ir, e_mv, e_sv;
      drive(r, d, v, m, s);
      #1;
      e_ir = !r && (q.size() < DEPTH);
      e_mv = !r && (q.size() > 0) && q[0];
      e_sv = !r && (q.size() > 0) && !q[0];
      check({tag, " ins_ready"},   int'(ins_ready),   int'(e_ir));
      check({tag, " match_valid"}, int'(match_valid), int'(e_mv));
      check({tag, " miss_valid"},  int'(miss_valid),  int'(e_sv));
      check({tag, " match_count"}, int'(match_count), m_mc);
      check({tag, " miss_count"},  int'(miss_count),  m_sc);
      model_step(r, d, v, m, s);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Hand-computed directed table: outputs expected during the row's cycle.
      //          rst  ins   iv m  s   ir mv sv mc sc
      tbl[0]  = '{1, TOK_M, 1, 1, 1,  0, 0, 0, 0, 0};
      tbl[1]  = '{1, TOK_M, 1, 1, 1,  0, 0, 0, 0, 0};
      tbl[2]  = '{0, TOK_M, 0, 1, 1,  1, 0, 0, 0, 0};
      tbl[3]  = '{0, TOK_M, 1, 1, 1,  1, 0, 0, 0, 0};
      tbl[4]  = '{0, TOK_X, 1, 1, 1,  1, 1, 0, 0, 0};
      tbl[5]  = '{0, TOK_X, 0, 1, 1,  1, 0, 1, 1, 0};
      tbl[6]  = '{0, TOK_X, 0, 1, 1,  1, 0, 0, 1, 1};
      tbl[7]  = '{0, TOK_M, 1, 0, 0,  1, 0, 0, 1, 1};
      tbl[8]  = '{0, TOK_M, 1, 0, 0,  1, 1, 0, 1, 1};
      tbl[9]  = '{0, TOK_X, 1, 0, 0,  0, 1, 0, 1, 1};
      tbl[10] = '{0, TOK_X, 1, 0, 1,  0, 1, 0, 1, 1};
      tbl[11] = '{0, TOK_X, 1, 1, 0,  0, 1, 0, 1, 1};
      tbl[12] = '{0, TOK_X, 1, 0, 0,  1, 1, 0, 2, 1};
      tbl[13] = '{0, TOK_X, 0, 1, 0,  0, 1, 0, 2, 1};
      tbl[14] = '{0, TOK_X, 0, 0, 1,  1, 0, 1, 3, 1};
      tbl[15] = '{0, TOK_X, 0, 0, 0,  1, 0, 0, 3, 2};

      drive(1, '0, 0, 0, 0);
      @(posedge clk);
      #1;
      model_step(1, '0, 0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].m, tbl[i].s);
         #1;
         check($sformatf("tbl%0d ins_ready", i),   int'(ins_ready),   int'(tbl[i].e_ir));
         check($sformatf("tbl%0d match_valid", i), int'(match_valid), int'(tbl[i].e_mv));
         check($sformatf("tbl%0d miss_valid", i),  int'(miss_valid),  int'(tbl[i].e_sv));
         check($sformatf("tbl%0d match_count", i), int'(match_count), tbl[i].e_mc);
         check($sformatf("tbl%0d miss_count", i),  int'(miss_count),  tbl[i].e_sc);
         model_step(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].m, tbl[i].s);
         @(posedge clk);
         #1;
      end

      // Saturation: 20 matching tokens into a 4-bit counter.
      do_cycle("sat_rst", 1, '0, 0, 1, 1);
      for (int i = 0; i < 20; i++) do_cycle("sat", 0, TOK_M, 1, 1, 1);
      for (int i = 0; i < 3; i++)  do_cycle("sat_drain", 0, TOK_M, 0, 1, 1);
      check("sat match_count stuck", int'(match_count), 15);
      check("sat miss_count", int'(miss_count), 0);

      // Reset mid-stream: counts 5/3 with two tokens buffered.
      do_cycle("mid_rst", 1, '0, 0, 1, 1);
      for (int i = 0; i < 5; i++) do_cycle("mid_m", 0, TOK_M, 1, 1, 1);
      for (int i = 0; i < 3; i++) do_cycle("mid_x", 0, TOK_X, 1, 1, 1);
      for (int i = 0; i < 2; i++) do_cycle("mid_idle", 0, TOK_X, 0, 1, 1);
      do_cycle("mid_fill_m", 0, TOK_M, 1, 0, 0);
      do_cycle("mid_fill_x", 0, TOK_X, 1, 0, 0);
      check("mid pre match_count", int'(match_count), 5);
      check("mid pre miss_count", int'(miss_count), 3);
      check("mid pre full", int'(ins_ready), 0);
      do_cycle("mid_pulse", 1, TOK_M, 1, 1, 1);
      check("mid post match_count", int'(match_count), 0);
      check("mid post miss_count", int'(miss_count), 0);
      for (int i = 0; i < 4; i++) do_cycle("mid_after", 0, TOK_M, 0, 1, 1);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         int          sel;
         sel = $urandom_range(0, 2);
         d   = (sel == 0) ? TOK_M : (sel == 1) ? TOK_X : $urandom;
         do_cycle("rand", ($urandom_range(0, 39) == 0), d,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/handshake_token_match.md
# handshake_token_match

Consumer-side counterpart to the constant-token source: accepts a data token, compares it against a compile-time constant, and turns it back into a control-only token on one of two output channels, `match` or `miss`. A small elastic buffer decouples the input from the outputs. Two saturating counters record how many tokens left on each channel. It sits at the tail of a datapath: checker logic, a dataflow branch driven by a constant, or the end-of-stream detector in generated handshake HDL.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of `ins`.
- `CONST_VALUE`, default 17'b01000000011100111: reference constant, zero-extended or truncated to `DATA_WIDTH`.
- `DEPTH`, default 2: buffer slots, must be at least 1.
- `COUNT_WIDTH`, default 16: width of each statistics counter.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ins`, input, DATA_WIDTH: input data token.
- `ins_valid`, input, 1: input token valid.
- `ins_ready`, output, 1: block can accept a token.
- `match_valid`, output, 1: head token equalled `CONST_VALUE`.
- `match_ready`, input, 1: downstream accepts the match token.
- `miss_valid`, output, 1: head token differed from `CONST_VALUE`.
- `miss_ready`, input, 1: downstream accepts the miss token.
- `match_count`, output, COUNT_WIDTH: completed match transfers.
- `miss_count`, output, COUNT_WIDTH: completed miss transfers.

## Operation
- Push: on `ins_valid && ins_ready`, the block computes `flag = (ins == CONST_VALUE)` and writes only that 1-bit flag into the FIFO tail. Data is not stored.
- Head routing:
  - `match_valid = !empty && head_flag`.
  - `miss_valid = !empty && !head_flag`.
  - The two are never high together.
- Pop: on `(match_valid && match_ready) || (miss_valid && miss_ready)`. The ready of the inactive channel is ignored.
- `ins_ready = !rst && (occupancy != DEPTH)`.
  - There is no full-bypass: when the FIFO is full, a same-cycle pop does not enable a push.
- Simultaneous push and pop with the FIFO not full: occupancy is unchanged, and the pointers advance modulo `DEPTH`.
- Pointers wrap at `DEPTH`, including depths that are not powers of two. Occupancy is an explicit counter from 0 to `DEPTH`.
- Counters:
  - `match_count` increments on each match pop, `miss_count` on each miss pop.
  - Each saturates at all-ones and never wraps.
- Valid is held: once an output valid is asserted, it stays high with the same routing until the token is popped. No token is dropped and no token is duplicated.
- Reset (synchronous, wins over every other event):
  - Occupancy, pointers and both counters clear to 0.
  - `match_valid = miss_valid = 0` and `ins_ready = 0` while `rst` is high.
  - Tokens in flight are discarded.
  - Any push or pop presented in the reset cycle is ignored.

## Timing
- Latency: a token accepted at edge N is visible on `match_valid`/`miss_valid` from cycle N+1.
- There is no combinational path from `ins`/`ins_valid` to the outputs.
- There is no combinational path from `match_ready`/`miss_ready` to `ins_ready`. `ins_ready` depends only on registered occupancy and `rst`.
- Outputs are combinational from registered state only.
- Throughput: 1 token per cycle when the consumer is always ready and `DEPTH >= 2`. With `DEPTH = 1`, throughput is 1 token per 2 cycles.
- Counters update at the edge where the transfer completes and are visible the following cycle.
- First cycle after `rst` deasserts: `ins_ready = 1` and both output valids are 0.

## Structure
- Shared package `handshake_pkg` holds:
  - the default constant `HS_CONST_64 = 17'b01000000011100111`;
  - a function that computes the pointer width from `DEPTH` (`clog2`, minimum 1).
- Sub-module `handshake_flag_fifo`, parameterised on `DEPTH`:
  - a 1-bit-wide synchronous FIFO with ports `push`, `pop`, `din`, `dout`, `empty`, `full`;
  - wrap and occupancy logic live here.
- The top level adds the comparator, the routing and the two saturating counters.

## Test plan
- Reset and idle: hold `rst` for 3 cycles, then release. Expect `ins_ready = 1`, both valids 0 and both counts 0 in the first cycle after release.
- Match and miss routing: push `ins = 0x000080E7` then `0x000080E6`, with both readies high.
  - `match_valid` is high in cycle N+1.
  - `miss_valid` is high in cycle N+2.
  - Final counts: match 1, miss 1.
- Backpressure and full: both readies 0, push 3 tokens with `DEPTH = 2`.
  - `ins_ready` drops after the second accept and the third token is held off.
  - Raise `match_ready` with a matching head: exactly one pop, and `ins_ready` rises the next cycle.
- Full with same-cycle pop: with the FIFO full, assert `ins_valid` and the correct ready together. Expect the pop to complete, the push to be refused that cycle, and the push to be accepted the next cycle.
- Saturation: `COUNT_WIDTH = 4`, stream 20 matching tokens. `match_count` sticks at 15.
- Reset mid-stream: with 2 tokens buffered and counts at 5 and 3, pulse `rst` for 1 cycle. Expect both valids 0 afterwards, counts 0, and no stale token emitted.
